touch_report_tx: RTL and testbench

- Transmit end of the touch-panel serial link: serializes touch reports (pen state, 12-bit X, 12-bit Y) into 5-byte 8N1 UART packets on touch_uart_TXD.
- Used as the touch-controller model driving the system's touch_uart_RXD, for on-board loopback and bench tests of the receive path without a physical panel.
- Report input is a single-entry valid/ready port fed from switches/buttons logic or a test sequencer.

---
 rtl/touch_pkg.sv | 34 +++
 rtl/uart_tx_byte.sv | 139 +++++++++++++
 rtl/touch_report_tx.sv | 98 +++++++++
 tb/tb_touch_report_tx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/touch_pkg.sv
// touch_pkg: shared types and constants for the touch-report transmitter.
//   PKT_BYTES    - bytes in one touch report packet
//   HDR_PEN_*    - header byte values (bit 7 marks a header, bit 0 = pen)
//   COORD_W      - coordinate width
//   state_t      - byte serializer FSM states
//   build_packet - packs pen/X/Y into the 5-byte packet, B0 in bits [7:0]
package touch_pkg;

    localparam int         PKT_BYTES    = 5;
    localparam logic [7:0] HDR_PEN_UP   = 8'h80;
    localparam logic [7:0] HDR_PEN_DOWN = 8'h81;
    localparam int         COORD_W      = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        GAP   = 3'd4
    } state_t;

    // Coordinates are split 7+5 so only the header byte ever has bit 7 set,
    // which lets the receiver resynchronise on the header.
    function automatic logic [8*PKT_BYTES-1:0] build_packet(
        input logic               pen,
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y
    );
        logic [7:0] hdr;
        hdr = pen ? HDR_PEN_DOWN : HDR_PEN_UP;
        return {3'b000, y[11:7], 1'b0, y[6:0], 3'b000, x[11:7], 1'b0, x[6:0], hdr};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer with optional inter-byte mark gap.
//   clk_i   - clock
//   rst_i   - asynchronous active-high reset
//   start_i - load data_i and begin a byte; honoured in IDLE and in the
//             done_o cycle (back-to-back bytes with no idle cycle)
//   data_i  - byte to send, LSB first
//   done_o  - combinational, high in the last cycle of the byte's final
//             bit period (stop bit, or last gap bit when GAP_BITS > 0)
//   txd_o   - registered serial output, idle high
module uart_tx_byte
    import touch_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int GAP_BITS     = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       done_o,
    output logic       txd_o
);

    localparam int                BAUD_W      = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    // Unreachable value when GAP_BITS is 0: the GAP state is then skipped.
    localparam logic [3:0]        GAP_LAST    = 4'(GAP_BITS - 1);

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [3:0]        gap_q, gap_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;

    logic bit_end;
    logic byte_end;

    assign bit_end = (baud_q == '0);
    assign txd_o   = txd_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            gap_q     <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            gap_q     <= gap_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        gap_d     = gap_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        byte_end  = 1'b0;

        // Inside a bit period just count down; transitions happen at bit_end.
        if (state_q != IDLE && !bit_end) begin
            baud_d = baud_q - 1'b1;
        end

        case (state_q)
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    baud_d    = BAUD_RELOAD;
                    bit_idx_d = '0;
                    txd_d     = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        // shift_q[0] is the bit now on the wire.
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = shift_q >> 1;
                        txd_d     = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (GAP_BITS == 0) begin
                        byte_end = 1'b1;
                    end else begin
                        state_d = GAP;
                        baud_d  = BAUD_RELOAD;
                        gap_d   = '0;
                    end
                end
            end
            GAP: begin
                if (bit_end) begin
                    if (gap_q == GAP_LAST) begin
                        byte_end = 1'b1;
                    end else begin
                        gap_d  = gap_q + 1'b1;
                        baud_d = BAUD_RELOAD;
                    end
                end
            end
            default: begin
                // IDLE: handled by the load logic below.
            end
        endcase

        if (byte_end) begin
            state_d = IDLE;
            txd_d   = 1'b1;
            gap_d   = '0;
        end

        if (start_i && (state_q == IDLE || byte_end)) begin
            state_d = START;
            baud_d  = BAUD_RELOAD;
            shift_d = data_i;
            txd_d   = 1'b0;
        end
    end

    assign done_o = byte_end;

endmodule

// File: rtl/touch_report_tx.sv
// touch_report_tx: serializes touch reports into 5-byte 8N1 UART packets.
//   clk_clk        - system clock
//   reset_reset    - asynchronous active-high reset
//   report_valid   - a report is presented
//   report_ready   - high only while idle; accept = valid && ready at posedge
//   report_pen     - 1 = pen down
//   report_x/_y    - 12-bit coordinates, sampled only at the accepting edge
//   touch_uart_TXD - serial output, idle high
//   busy           - packet in flight (complement of report_ready)
//
// Handshake: a report transfers on a rising edge where report_valid and
// report_ready are both high; report_valid is ignored while busy.
module touch_report_tx
    import touch_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int GAP_BITS     = 0
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic               report_valid,
    output logic               report_ready,
    input  logic               report_pen,
    input  logic [COORD_W-1:0] report_x,
    input  logic [COORD_W-1:0] report_y,
    output logic               touch_uart_TXD,
    output logic               busy
);

    logic        busy_q, busy_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    // Holds B1..B4; B0 goes straight to the serializer at the accepting edge.
    logic [31:0] pkt_q, pkt_d;

    logic [8*PKT_BYTES-1:0] pkt_full;
    logic                   accept;
    logic                   ser_start;
    logic [7:0]             ser_data;
    logic                   ser_done;

    assign pkt_full = build_packet(report_pen, report_x, report_y);
    assign accept   = report_valid && !busy_q;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            busy_q     <= 1'b0;
            byte_idx_q <= '0;
            pkt_q      <= '0;
        end else begin
            busy_q     <= busy_d;
            byte_idx_q <= byte_idx_d;
            pkt_q      <= pkt_d;
        end
    end

    always_comb begin
        busy_d     = busy_q;
        byte_idx_d = byte_idx_q;
        pkt_d      = pkt_q;
        ser_start  = 1'b0;
        ser_data   = pkt_q[7:0];

        if (accept) begin
            busy_d     = 1'b1;
            byte_idx_d = '0;
            pkt_d      = pkt_full[39:8];
            ser_start  = 1'b1;
            ser_data   = pkt_full[7:0];
        end else if (ser_done) begin
            if (byte_idx_q == 3'(PKT_BYTES - 1)) begin
                busy_d     = 1'b0;
                byte_idx_d = '0;
            end else begin
                // Chain the next byte in the done cycle so its start bit
                // follows the previous stop/gap period without a gap.
                ser_start  = 1'b1;
                byte_idx_d = byte_idx_q + 1'b1;
                pkt_d      = pkt_q >> 8;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .GAP_BITS    (GAP_BITS)
    ) u_ser (
        .clk_i  (clk_clk),
        .rst_i  (reset_reset),
        .start_i(ser_start),
        .data_i (ser_data),
        .done_o (ser_done),
        .txd_o  (touch_uart_TXD)
    );

    assign report_ready = !busy_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_touch_report_tx.sv
module tb_touch_report_tx;
  localparam int CPB = 4;

  typedef struct {
    logic        pen;
    logic [11:0] x;
    logic [11:0] y;
    logic [39:0] bytes;  // B0 in [7:0] ... B4 in [39:32]
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v0, v2, pen;
  logic [11:0] x, y;
  logic        rdy0, rdy2, txd0, txd2, busy0, busy2;

  touch_report_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(0)) dut0 (
    .clk_clk(clk), .reset_reset(rst), .report_valid(v0), .report_ready(rdy0),
    .report_pen(pen), .report_x(x), .report_y(y), .touch_uart_TXD(txd0), .busy(busy0)
  );

  touch_report_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(2)) dut2 (
    .clk_clk(clk), .reset_reset(rst), .report_valid(v2), .report_ready(rdy2),
    .report_pen(pen), .report_x(x), .report_y(y), .touch_uart_TXD(txd2), .busy(busy2)
  );

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [0:0] exp_q[$];
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic get_txd(input bit sel);
    return sel ? txd2 : txd0;
  endfunction

  function automatic logic get_rdy(input bit sel);
    return sel ? rdy2 : rdy0;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? busy2 : busy0;
  endfunction

  task automatic set_valid(input bit sel, input logic val);
    if (sel) v2 = val;
    else v0 = val;
  endtask

  // driver tasks (called at a negedge, return at a negedge)
  task automatic wait_ready(input bit sel, input string tag);
    int n;
    n = 0;
    while (get_rdy(sel) !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (get_rdy(sel) !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_ready_timeout actual=0 required=1 after %0d cycles", tag, n);
    end
  endtask

  task automatic run_packet(input bit sel, input vec_t v, input string tag, input bit hold);
    int         g, per_byte;
    logic [7:0] eb, ab;
    int         berr;
    logic       t, e, rdy_bad;
    g = sel ? 2 : 0;
    per_byte = (10 + g) * CPB;
    wait_ready(sel, tag);
    pen = v.pen;
    x = v.x;
    y = v.y;
    set_valid(sel, 1'b1);
    exp_q.delete();
    for (int b = 0; b < 5; b++) begin
      eb = v.bytes[8*b +: 8];
      for (int i = 0; i < CPB; i++) exp_q.push_back(1'b0);
      for (int k = 0; k < 8; k++)
        for (int i = 0; i < CPB; i++) exp_q.push_back(eb[k]);
      for (int i = 0; i < (1 + g) * CPB; i++) exp_q.push_back(1'b1);
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) set_valid(sel, 1'b0);
    rdy_bad = 1'b0;
    for (int b = 0; b < 5; b++) begin
      berr = 0;
      ab = '0;
      eb = v.bytes[8*b +: 8];
      for (int i = 0; i < per_byte; i++) begin
        t = get_txd(sel);
        e = exp_q.pop_front();
        if (t !== e) berr++;
        if (i >= CPB && i < 9 * CPB && (i % CPB) == CPB / 2) ab[(i / CPB) - 1] = t;
        if (get_rdy(sel) !== 1'b0 || get_busy(sel) !== 1'b1) rdy_bad = 1'b1;
        if (hold) begin
          x = 12'($urandom_range(0, 4095));
          y = 12'($urandom_range(0, 4095));
          pen = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
      end
      checks++;
      if (berr != 0) begin
        failures++;
        $display("FAIL %s_byte%0d actual=0x%02h required=0x%02h bad_cycles=%0d",
                 tag, b, ab, eb, berr);
      end
    end
    check({tag, "_ready_low_in_packet"}, 32'(rdy_bad), 32'd0);
    check({tag, "_ready_after"}, 32'(get_rdy(sel)), 32'd1);
    check({tag, "_busy_after"}, 32'(get_busy(sel)), 32'd0);
    check({tag, "_txd_after"}, 32'(get_txd(sel)), 32'd1);
  endtask

  logic bad_txd, bad_rdy;

  initial begin
    vecs[0] = '{pen: 1'b1, x: 12'h123, y: 12'hABC, bytes: {8'h15, 8'h3C, 8'h02, 8'h23, 8'h81}};
    vecs[1] = '{pen: 1'b0, x: 12'hFFF, y: 12'h000, bytes: {8'h00, 8'h00, 8'h1F, 8'h7F, 8'h80}};
    vecs[2] = '{pen: 1'b1, x: 12'h080, y: 12'h07F, bytes: {8'h00, 8'h7F, 8'h01, 8'h00, 8'h81}};
    vecs[3] = '{pen: 1'b0, x: 12'hAAA, y: 12'h555, bytes: {8'h0A, 8'h55, 8'h15, 8'h2A, 8'h80}};

    rst = 1'b1;
    v0 = 1'b0;
    v2 = 1'b0;
    pen = 1'b0;
    x = '0;
    y = '0;
    repeat (3) @(negedge clk);
    check("reset_txd0", 32'(txd0), 32'd1);
    check("reset_ready0", 32'(rdy0), 32'd1);
    check("reset_busy0", 32'(busy0), 32'd0);
    check("reset_txd2", 32'(txd2), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // table-driven packets, GAP_BITS=0
    for (int i = 0; i < 4; i++) run_packet(1'b0, vecs[i], $sformatf("vec%0d", i), 1'b0);

    // inputs scrambled and valid held during a packet; next accepted at ready rise
    run_packet(1'b0, vecs[0], "hold_a", 1'b1);
    run_packet(1'b0, vecs[3], "hold_b", 1'b0);

    // GAP_BITS=2
    run_packet(1'b1, vecs[0], "gap2", 1'b0);

    // reset in the middle of B2 (cycle 94 is data bit 2 of 0x02, a 0)
    wait_ready(1'b0, "rst_seq");
    pen = vecs[0].pen;
    x = vecs[0].x;
    y = vecs[0].y;
    v0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    repeat (93) @(negedge clk);
    check("pre_reset_txd", 32'(txd0), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("mid_reset_txd", 32'(txd0), 32'd1);
    check("mid_reset_ready", 32'(rdy0), 32'd1);
    check("mid_reset_busy", 32'(busy0), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad_txd = 1'b0;
    bad_rdy = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd0 !== 1'b1) bad_txd = 1'b1;
      if (rdy0 !== 1'b1) bad_rdy = 1'b1;
    end
    check("post_reset_no_residual_txd", 32'(bad_txd), 32'd0);
    check("post_reset_ready", 32'(bad_rdy), 32'd0);
    run_packet(1'b0, vecs[1], "post_reset", 1'b0);

    // long idle
    bad_txd = 1'b0;
    bad_rdy = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (txd0 !== 1'b1 || txd2 !== 1'b1) bad_txd = 1'b1;
      if (busy0 !== 1'b0 || busy2 !== 1'b0) bad_rdy = 1'b1;
    end
    check("idle_txd_high", 32'(bad_txd), 32'd0);
    check("idle_not_busy", 32'(bad_rdy), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
